alu_seq: RTL
============

Name: alu_seq

Overview:
- Multi-cycle MIPS ALU datapath that consumes the 6-bit ALUctrl code produced by the ALU controller and executes it on two 32-bit operands.
- Logic, arithmetic, compare, LUI and fixed-amount shift codes complete in one cycle.
- MULTU (0x13) runs an iterative shift-add multiplier and writes the internal hi/lo registers.
- Sits in the EX stage; the pipeline stalls on busy.

Parameters:
- WIDTH, 32, operand/result width; hi/lo are WIDTH each.
- MUL_CYCLES, 32, iterations per MULTU in the radix-2 build; must equal WIDTH.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-high reset.
- ALUctrl  in  6  operation code, sampled with start.
- a  in  WIDTH  operand A (rs).
- b  in  WIDTH  operand B (rt or immediate); shift and LUI source.
- start  in  1  request; accepted only in IDLE.
- busy  out  1  high while an operation is in flight.
- done  out  1  one-cycle pulse; result, zero and ovf are valid in that cycle.
- result  out  WIDTH  registered result.
- zero  out  1  (result == 0), registered with result.
- ovf  out  1  signed overflow, ADD (0x02) only.
- hi  out  WIDTH  multiply high word.
- lo  out  WIDTH  multiply low word.

Behaviour:
- Reset (async, any state): state IDLE; busy, done, ovf = 0; result, hi, lo = 0; zero = 1; any multiply in progress is aborted.
- FSM states: IDLE, EXEC, MUL, DONE.
  - IDLE, start=1, code != 0x13: latch a, b and code; go to EXEC.
  - IDLE, start=1, code == 0x13: latch a, b; go to MUL; load counter with MUL_CYCLES.
  - EXEC: compute and register result/zero/ovf; pulse done; return to IDLE. Latency: accepted at cycle t, done at t+1.
  - MUL: one iteration per cycle, counter decrements; at counter == 1 go to DONE.
  - DONE: write {hi,lo} = a*b (unsigned, 2*WIDTH bits); result = lo; pulse done; return to IDLE. Done at t+MUL_CYCLES+1 (t+33 by default).
- busy = (state != IDLE). start while busy is ignored and not queued. Back-to-back requests: start may be asserted in the done cycle, is accepted in the following IDLE cycle, and gives at most one idle bubble.
- Op codes (hex):
  - 00 AND, 01 OR, 04 XOR.
  - 02 ADD signed (wraps, ovf flagged); 03 ADDU; 06 SUB (a-b, wraps, no ovf).
  - 07 SLT signed, 08 SLTU; result is 0 or 1.
  - 09 LUI: b[15:0] << 16.
  - 0A/0B/0C: SLL b by 1/2/8. 0D/0E/0F: SRL b by 1/2/8. 10/11/12: SRA b by 1/2/8.
  - 13 MULTU.
  - 14 and all undefined codes: result 0, one-cycle latency, done still pulses.
- ovf = (a[31] == b[31]) && (sum[31] != a[31]) for code 02; 0 for all other codes.
- hi/lo change only on MULTU completion. MFHI/MFLO reach this block as code 00 and read the hi/lo ports directly.
- result, zero and ovf hold their values between operations.

Optional Feature:
- Macro ALU_MUL_RADIX4_EN.
- Defined: the multiplier retires 2 bits per cycle (partial products 0, a, 2a, 3a), taking 16 iterations; MULTU done at t+17.
- Undefined: radix-2, 32 iterations, done at t+33.
- Results are bit-identical in both builds.

Decomposition:
- Shared package alu_pkg:
  - localparams for every ALUctrl code (ALU_AND ... ALU_MULTU, ALU_RSVD14);
  - FSM state encoding;
  - iteration count selected by the macro.
- Sub-module alu_mul_seq: iterative unsigned multiplier with load/step/last handshake, accumulator and counter. alu_seq owns the FSM, single-cycle datapath, hi/lo and outputs.

Test Plan:
- ADD a=0x7FFFFFFF, b=0x00000001, start at t -> done at t+1; result 0x80000000, ovf=1, zero=0, busy high only in t+1.
- SUB a=5, b=7 -> 0xFFFFFFFE. SUB a=b=9 -> result 0, zero=1. SLT a=0xFFFFFFFF, b=1 -> 1; SLTU with the same operands -> 0.
- Shifts/LUI with b=0x80000001: SLL8 -> 0x00000100, SRL2 -> 0x20000000, SRA8 -> 0xFF800000. LUI with b=0x1234 -> 0x12340000. Code 0x14 -> result 0, done at t+1.
- MULTU a=b=0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001 = result; busy high t+1..t+33; done at t+33 (t+17 with ALU_MUL_RADIX4_EN). A start at t+5 is ignored. A following ADD leaves hi/lo unchanged.
- Assert reset at the 10th MUL cycle -> busy=0, hi=lo=0, result=0, zero=1 asynchronously. After release, MULTU 3*5 -> lo=15, hi=0.
- Start asserted in the done cycle of an AND -> next op accepted the following cycle; no request lost or duplicated across 100 random back-to-back ops checked against a reference model.

Source files
------------

// File: rtl/alu_pkg.sv
// ============================================================================
//  alu_pkg
//  Shared ALUctrl codes, FSM encoding and multiplier step size for alu_seq.
//  Build option: ALU_MUL_RADIX4_EN selects a 2-bit-per-cycle multiplier.
//  Revision: 1.0
// ============================================================================
`default_nettype none

package alu_pkg;

    localparam logic [5:0] ALU_AND    = 6'h00;
    localparam logic [5:0] ALU_OR     = 6'h01;
    localparam logic [5:0] ALU_ADD    = 6'h02;
    localparam logic [5:0] ALU_ADDU   = 6'h03;
    localparam logic [5:0] ALU_XOR    = 6'h04;
    localparam logic [5:0] ALU_SUB    = 6'h06;
    localparam logic [5:0] ALU_SLT    = 6'h07;
    localparam logic [5:0] ALU_SLTU   = 6'h08;
    localparam logic [5:0] ALU_LUI    = 6'h09;
    localparam logic [5:0] ALU_SLL1   = 6'h0A;
    localparam logic [5:0] ALU_SLL2   = 6'h0B;
    localparam logic [5:0] ALU_SLL8   = 6'h0C;
    localparam logic [5:0] ALU_SRL1   = 6'h0D;
    localparam logic [5:0] ALU_SRL2   = 6'h0E;
    localparam logic [5:0] ALU_SRL8   = 6'h0F;
    localparam logic [5:0] ALU_SRA1   = 6'h10;
    localparam logic [5:0] ALU_SRA2   = 6'h11;
    localparam logic [5:0] ALU_SRA8   = 6'h12;
    localparam logic [5:0] ALU_MULTU  = 6'h13;
    localparam logic [5:0] ALU_RSVD14 = 6'h14;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_MUL  = 2'd2,
        ST_DONE = 2'd3
    } alu_state_t;

    // Multiplier bits retired per iteration; iteration count is WIDTH / this.
`ifdef ALU_MUL_RADIX4_EN
    localparam int ALU_MUL_STEP_BITS = 2;
`else
    localparam int ALU_MUL_STEP_BITS = 1;
`endif

endpackage

`default_nettype wire

// File: rtl/alu_mul_seq.sv
// ============================================================================
//  alu_mul_seq
//  Iterative unsigned shift-add multiplier, 1 or 2 multiplier bits per step.
//  Revision: 1.0
// ============================================================================
`default_nettype none

module alu_mul_seq #(
    parameter int WIDTH     = 32,
    parameter int ITERS     = 32,
    parameter int STEP_BITS = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 i_load,
    input  logic                 i_step,
    input  logic [WIDTH-1:0]     i_a,
    input  logic [WIDTH-1:0]     i_b,
    output logic                 o_last,
    output logic [2*WIDTH-1:0]   o_prod_next
);

    localparam int CNT_W = $clog2(ITERS + 1);

    logic [WIDTH-1:0]   r_mcand;
    logic [2*WIDTH-1:0] r_acc;
    logic [CNT_W-1:0]   r_cnt;
    logic [1:0]         w_digit;
    logic [WIDTH+1:0]   w_pp;
    logic [WIDTH+1:0]   w_sum;

    // Accumulator holds {partial high word, unconsumed multiplier bits}.
    always_comb begin
        w_digit = (STEP_BITS == 2) ? r_acc[1:0] : {1'b0, r_acc[0]};
        case (w_digit)
            2'd0:    w_pp = '0;
            2'd1:    w_pp = {2'b00, r_mcand};
            2'd2:    w_pp = {1'b0, r_mcand, 1'b0};
            default: w_pp = {2'b00, r_mcand} + {1'b0, r_mcand, 1'b0};
        endcase
        w_sum       = {2'b00, r_acc[2*WIDTH-1:WIDTH]} + w_pp;
        o_prod_next = (2*WIDTH)'({w_sum, r_acc[WIDTH-1:0]} >> STEP_BITS);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_mcand <= '0;
            r_acc   <= '0;
            r_cnt   <= '0;
        end else if (i_load) begin
            r_mcand <= i_a;
            r_acc   <= {{WIDTH{1'b0}}, i_b};
            r_cnt   <= CNT_W'(ITERS);
        end else if (i_step) begin
            r_acc   <= o_prod_next;
            r_cnt   <= r_cnt - CNT_W'(1);
        end
    end

    assign o_last = (r_cnt == CNT_W'(1));

endmodule

`default_nettype wire

// File: rtl/alu_seq.sv
// ============================================================================
//  alu_seq
//  Multi-cycle MIPS EX-stage ALU: single-cycle ops plus iterative MULTU.
//  Build option: ALU_MUL_RADIX4_EN (radix-4 multiplier, MULTU done at t+17).
//  Revision: 1.0
// ============================================================================
`default_nettype none

module alu_seq
    import alu_pkg::*;
#(
    parameter int WIDTH      = 32,
    parameter int MUL_CYCLES = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [5:0]       ALUctrl,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             start,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             ovf,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int MUL_ITERS = MUL_CYCLES / ALU_MUL_STEP_BITS;

    alu_state_t         r_state;
    alu_state_t         w_state_next;
    logic               w_is_mul;
    logic               w_accept;
    logic               w_mul_step;
    logic               w_mul_last;
    logic [2*WIDTH-1:0] w_prod_next;
    logic [WIDTH-1:0]   w_sum;
    logic [WIDTH-1:0]   w_res;
    logic               w_ovf;
    logic [WIDTH-1:0]   r_result;
    logic [WIDTH-1:0]   r_hi;
    logic [WIDTH-1:0]   r_lo;
    logic               r_zero;
    logic               r_ovf;

    assign w_is_mul   = (ALUctrl == ALU_MULTU);
    assign w_accept   = start && (r_state == ST_IDLE);
    assign w_mul_step = (r_state == ST_MUL);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= ST_IDLE;
        else       r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: if (start) w_state_next = w_is_mul ? ST_MUL : ST_EXEC;
            ST_EXEC: w_state_next = ST_IDLE;
            ST_MUL:  if (w_mul_last) w_state_next = ST_DONE;
            ST_DONE: w_state_next = ST_IDLE;
            default: w_state_next = ST_IDLE;
        endcase
    end

    // Single-cycle ops are evaluated on the accepting edge so the registered
    // result is already valid during the following (EXEC/done) cycle.
    always_comb begin
        w_sum = a + b;
        w_res = '0;
        w_ovf = 1'b0;
        case (ALUctrl)
            ALU_AND:  w_res = a & b;
            ALU_OR:   w_res = a | b;
            ALU_XOR:  w_res = a ^ b;
            ALU_ADD: begin
                w_res = w_sum;
                w_ovf = (a[WIDTH-1] == b[WIDTH-1]) && (w_sum[WIDTH-1] != a[WIDTH-1]);
            end
            ALU_ADDU: w_res = w_sum;
            ALU_SUB:  w_res = a - b;
            ALU_SLT:  w_res = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
            ALU_SLTU: w_res = {{(WIDTH-1){1'b0}}, (a < b)};
            ALU_LUI:  w_res = {{(WIDTH-16){1'b0}}, b[15:0]} << 16;
            ALU_SLL1: w_res = b << 1;
            ALU_SLL2: w_res = b << 2;
            ALU_SLL8: w_res = b << 8;
            ALU_SRL1: w_res = b >> 1;
            ALU_SRL2: w_res = b >> 2;
            ALU_SRL8: w_res = b >> 8;
            ALU_SRA1: w_res = $signed(b) >>> 1;
            ALU_SRA2: w_res = $signed(b) >>> 2;
            ALU_SRA8: w_res = $signed(b) >>> 8;
            default:  w_res = '0;
        endcase
    end

    alu_mul_seq #(
        .WIDTH     (WIDTH),
        .ITERS     (MUL_ITERS),
        .STEP_BITS (ALU_MUL_STEP_BITS)
    ) u_mul (
        .clk         (clk),
        .rst         (reset),
        .i_load      (w_accept && w_is_mul),
        .i_step      (w_mul_step),
        .i_a         (a),
        .i_b         (b),
        .o_last      (w_mul_last),
        .o_prod_next (w_prod_next)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_result <= '0;
            r_zero   <= 1'b1;
            r_ovf    <= 1'b0;
            r_hi     <= '0;
            r_lo     <= '0;
        end else if (w_accept && !w_is_mul) begin
            r_result <= w_res;
            r_zero   <= (w_res == '0);
            r_ovf    <= w_ovf;
        end else if (w_mul_step && w_mul_last) begin
            r_hi     <= w_prod_next[2*WIDTH-1:WIDTH];
            r_lo     <= w_prod_next[WIDTH-1:0];
            r_result <= w_prod_next[WIDTH-1:0];
            r_zero   <= (w_prod_next[WIDTH-1:0] == '0);
            r_ovf    <= 1'b0;
        end
    end

    assign busy   = (r_state != ST_IDLE);
    assign done   = (r_state == ST_EXEC) || (r_state == ST_DONE);
    assign result = r_result;
    assign zero   = r_zero;
    assign ovf    = r_ovf;
    assign hi     = r_hi;
    assign lo     = r_lo;

endmodule

`default_nettype wire
